// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer.
package shift_pkg;

    localparam int DATA_W   = 64;
    localparam int AMT_W    = 6;

    localparam int STAGE_16 = 16;
    localparam int STAGE_4  = 4;
    localparam int STAGE_1  = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_stage_mux.sv
// Combinational selection of one fixed-distance shift stage (16, 4 or 1) from the remaining amount.
module shift_stage_mux
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [AMT_W-1:0]  rem,
    input  logic              rot,
    output logic [DATA_W-1:0] data_next,
    output logic [AMT_W-1:0]  rem_next
);

    logic [STAGE_16-1:0] fill_16;
    logic [STAGE_4-1:0]  fill_4;
    logic                fill_1;

    // Rotate refills from the bits leaving the top; otherwise zero-fill.
    assign fill_16 = rot ? data[DATA_W-1 -: STAGE_16] : '0;
    assign fill_4  = rot ? data[DATA_W-1 -: STAGE_4]  : '0;
    assign fill_1  = rot ? data[DATA_W-1]             : 1'b0;

    always_comb begin
        data_next = {data[DATA_W-STAGE_1-1:0], fill_1};
        rem_next  = rem - AMT_W'(STAGE_1);
        if (rem >= AMT_W'(STAGE_16)) begin
            data_next = {data[DATA_W-STAGE_16-1:0], fill_16};
            rem_next  = rem - AMT_W'(STAGE_16);
        end else if (rem >= AMT_W'(STAGE_4)) begin
            data_next = {data[DATA_W-STAGE_4-1:0], fill_4};
            rem_next  = rem - AMT_W'(STAGE_4);
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle 64-bit left shifter time-sharing one 16/4/1 stage mux under a valid/ready FSM.
// Optional rotate mode is enabled with the SHIFT_SEQ_ROTATE_EN macro.
module shift_sequencer
    import shift_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_amt,
`ifdef SHIFT_SEQ_ROTATE_EN
    input  logic              rotate,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] data_q;
    logic [AMT_W-1:0]  rem_q;
    logic [DATA_W-1:0] stage_data;
    logic [AMT_W-1:0]  stage_rem;
    logic              rot_sel;
    logic              accept;

    assign accept = (state == IDLE) && in_valid;

`ifdef SHIFT_SEQ_ROTATE_EN
    logic rot_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rot_q <= 1'b0;
        end else if (accept) begin
            rot_q <= rotate;
        end
    end

    assign rot_sel = rot_q;
`else
    assign rot_sel = 1'b0;
`endif

    shift_stage_mux u_stage (
        .data      (data_q),
        .rem       (rem_q),
        .rot       (rot_sel),
        .data_next (stage_data),
        .rem_next  (stage_rem)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = (in_amt != '0) ? SHIFT : DONE;
            SHIFT:   if (stage_rem == '0) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            rem_q  <= '0;
        end else if (accept) begin
            data_q <= in_data;
            rem_q  <= in_amt;
        end else if (state == SHIFT) begin
            data_q <= stage_data;
            rem_q  <= stage_rem;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    // Expose the result only while it is valid so the bus reads zero otherwise.
    assign out_data  = (state == DONE) ? data_q : '0;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer (rotate case active with SHIFT_SEQ_ROTATE_EN).
module tb_shift_sequencer;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [5:0]  in_amt;
    logic        rotate;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;

    int pass_cnt;
    int total_cnt;

    shift_sequencer dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
`ifdef SHIFT_SEQ_ROTATE_EN
        .rotate    (rotate),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Accepts one operation, then counts edges (accept edge = 1) until out_valid.
    task automatic run_op(input string name, input logic [63:0] d, input logic [5:0] a,
                          input logic r, input int exp_lat, input logic [63:0] exp_data);
        int lat;
        @(negedge clock);
        in_data  = d;
        in_amt   = a;
        rotate   = r;
        in_valid = 1'b1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL %s_ready: got %b want 1", name, in_ready);
        else pass_cnt++;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
        end
        total_cnt++;
        if (lat !== exp_lat) $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
        else pass_cnt++;
        total_cnt++;
        if (out_data !== exp_data) $display("FAIL %s_data: got %h want %h", name, out_data, exp_data);
        else pass_cnt++;
        // Let the handshake complete (out_ready is high in these cases).
        @(posedge clock);
        #1;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL %s_release: got in_ready=%b out_valid=%b want 1/0", name, in_ready, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        rotate    = 1'b0;
        out_ready = 1'b1;
        reset_n   = 1'b0;
        #12;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_ctrl: got ready=%b valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
        else pass_cnt++;
        total_cnt++;
        if (out_data !== 64'h0) $display("FAIL reset_data: got %h want 0", out_data);
        else pass_cnt++;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset_mid_shift();
        @(negedge clock);
        in_data  = 64'h1;
        in_amt   = 6'd63;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #2;
        total_cnt++;
        if (busy !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL midshift_busy: got busy=%b ready=%b want 1/0", busy, in_ready);
        else pass_cnt++;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL midshift_reset: got ready=%b valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
        else pass_cnt++;
        @(negedge clock);
        reset_n = 1'b1;
        run_op("after_reset", 64'h0000_0000_0000_ABCD, 6'd16, 1'b0, 2, 64'h0000_0000_ABCD_0000);
    endtask

    task automatic test_shift();
        run_op("amt0",  64'h0000_0000_0000_ABCD, 6'd0,  1'b0, 1, 64'h0000_0000_0000_ABCD);
        run_op("amt16", 64'h0000_0000_0000_ABCD, 6'd16, 1'b0, 2, 64'h0000_0000_ABCD_0000);
        run_op("amt21", 64'hFFFF_FFFF_FFFF_FFFF, 6'd21, 1'b0, 4, 64'hFFFF_FFFF_FFE0_0000);
        run_op("amt7",  64'h0123_4567_89AB_CDEF, 6'd7,  1'b0, 5, 64'h91A2_B3C4_D5E6_F780);
        run_op("amt1",  64'hC000_0000_0000_0003, 6'd1,  1'b0, 2, 64'h8000_0000_0000_0006);
    endtask

    task automatic test_backpressure();
        int lat;
        logic ok;
        out_ready = 1'b0;
        @(negedge clock);
        in_data  = 64'h1;
        in_amt   = 6'd63;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        // Held in_valid with new data must be ignored while busy.
        in_data = 64'hDEAD_BEEF_0000_FFFF;
        in_amt  = 6'd5;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        total_cnt++;
        if (lat !== 10) $display("FAIL bp_latency: got %0d want 10", lat);
        else pass_cnt++;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 64'h8000_0000_0000_0000) ok = 1'b0;
        end
        total_cnt++;
        if (ok !== 1'b1)
            $display("FAIL bp_hold: got valid=%b ready=%b data=%h want 1/0/8000000000000000", out_valid, in_ready, out_data);
        else pass_cnt++;
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL bp_release: got ready=%b valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
        else pass_cnt++;
    endtask

`ifdef SHIFT_SEQ_ROTATE_EN
    task automatic test_rotate();
        run_op("rot4",  64'hF000_0000_0000_0001, 6'd4,  1'b1, 2, 64'h0000_0000_0000_001F);
        run_op("rot21", 64'h8000_0000_0000_0001, 6'd21, 1'b1, 4, 64'h0000_0000_0030_0000);
        run_op("norot", 64'hF000_0000_0000_0001, 6'd4,  1'b0, 2, 64'h0000_0000_0000_0010);
    endtask
`endif

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_shift();
        test_backpressure();
        test_reset_mid_shift();
`ifdef SHIFT_SEQ_ROTATE_EN
        test_rotate();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
